// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode, EX/MEM and MEM/WB operand
// forwarding, load-use hazard detection and branch flush.
module id_ex_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          flush_i,
   input  logic          id_valid_i,
   input  logic [DW-1:0] id_rsData_i,
   input  logic [DW-1:0] id_rtData_i,
   input  logic [DW-1:0] id_imm_i,
   input  logic [RW-1:0] id_rs_i,
   input  logic [RW-1:0] id_rt_i,
   input  logic [RW-1:0] id_rd_i,
   input  logic [1:0]    id_aluOp_i,
   input  logic [5:0]    id_funct_i,
   input  logic [6:0]    id_ctrl_i,
   input  logic          exm_regWrite_i,
   input  logic [RW-1:0] exm_rd_i,
   input  logic [DW-1:0] exm_result_i,
   input  logic          mwb_regWrite_i,
   input  logic [RW-1:0] mwb_rd_i,
   input  logic [DW-1:0] mwb_data_i,
   output logic          stall_o,
   output logic          ex_valid_o,
   output logic [DW-1:0] ex_in1_o,
   output logic [DW-1:0] ex_in2_o,
   output logic [2:0]    ex_aluControl_o,
   output logic [DW-1:0] ex_storeData_o,
   output logic [RW-1:0] ex_destReg_o,
   output logic [4:0]    ex_ctrl_o
);

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // id_ctrl_i = {aluSrc, regDst, regWrite, memRead, memWrite, memToReg, branch}
   localparam int C_ALUSRC = 6;
   localparam int C_REGDST = 5;
   localparam int X_MEMRD  = 3;   // memRead position within the 5-bit EX control

   typedef struct packed {
      logic          valid;
      logic          aluSrc;
      logic [4:0]    ctrl;
      logic [2:0]    aluCtl;
      logic [RW-1:0] rs;
      logic [RW-1:0] rt;
      logic [RW-1:0] destReg;
      logic [DW-1:0] rsData;
      logic [DW-1:0] rtData;
      logic [DW-1:0] imm;
   } idex_t;

   idex_t         idex_d, idex_q;
   logic [2:0]    alu_dec;
   logic [DW-1:0] fwd_a, fwd_b;

   always_comb begin
      alu_dec = ALU_ADD;
      unique case (id_aluOp_i)
         2'b01:   alu_dec = ALU_SUB;
         2'b10: begin
            unique case (id_funct_i)
               6'b100010: alu_dec = ALU_SUB;
               6'b100100: alu_dec = ALU_AND;
               6'b100101: alu_dec = ALU_OR;
               6'b101010: alu_dec = ALU_SLT;
               default:   alu_dec = ALU_ADD;
            endcase
         end
         default: alu_dec = ALU_ADD;
      endcase
   end

   // Load-use: the consumer in ID must wait one cycle for the load data.
   assign stall_o = id_valid_i & idex_q.valid & idex_q.ctrl[X_MEMRD]
                  & (idex_q.destReg != '0)
                  & ((idex_q.destReg == id_rs_i) | (idex_q.destReg == id_rt_i));

   always_comb begin
      idex_d = '0;
      if (!(flush_i | stall_o)) begin
         idex_d.valid   = id_valid_i;
         idex_d.aluSrc  = id_ctrl_i[C_ALUSRC];
         idex_d.ctrl    = id_valid_i ? id_ctrl_i[4:0] : 5'b0;
         idex_d.aluCtl  = alu_dec;
         idex_d.rs      = id_rs_i;
         idex_d.rt      = id_rt_i;
         idex_d.destReg = id_ctrl_i[C_REGDST] ? id_rd_i : id_rt_i;
         idex_d.rsData  = id_rsData_i;
         idex_d.rtData  = id_rtData_i;
         idex_d.imm     = id_imm_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) idex_q <= '0;
      else          idex_q <= idex_d;
   end

   // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
   function automatic logic [DW-1:0] fwd(input logic [RW-1:0] r,
                                         input logic [DW-1:0] rf);
      if (exm_regWrite_i && exm_rd_i != '0 && exm_rd_i == r)      return exm_result_i;
      else if (mwb_regWrite_i && mwb_rd_i != '0 && mwb_rd_i == r) return mwb_data_i;
      else                                                        return rf;
   endfunction

   assign fwd_a = fwd(idex_q.rs, idex_q.rsData);
   assign fwd_b = fwd(idex_q.rt, idex_q.rtData);

   assign ex_valid_o      = idex_q.valid;
   assign ex_in1_o        = fwd_a;
   assign ex_in2_o        = idex_q.aluSrc ? idex_q.imm : fwd_b;
   assign ex_storeData_o  = fwd_b;
   assign ex_aluControl_o = idex_q.aluCtl;
   assign ex_destReg_o    = idex_q.destReg;
   assign ex_ctrl_o       = idex_q.ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, decode, forwarding, load-use stall,
// flush and immediate operand path.
module tb_id_ex_stage;
   localparam int DW = 32;
   localparam int RW = 5;

   localparam logic [6:0] C_RTYPE = 7'b0110000; // regDst, regWrite
   localparam logic [6:0] C_LW    = 7'b1011010; // aluSrc, regWrite, memRead, memToReg
   localparam logic [6:0] C_SW    = 7'b1000100; // aluSrc, memWrite
   localparam logic [6:0] C_ADDI  = 7'b1010000; // aluSrc, regWrite

   logic          clk = 1'b0;
   logic          rst_n, flush, id_valid;
   logic [DW-1:0] id_rsData, id_rtData, id_imm;
   logic [RW-1:0] id_rs, id_rt, id_rd;
   logic [1:0]    id_aluOp;
   logic [5:0]    id_funct;
   logic [6:0]    id_ctrl;
   logic          exm_regWrite, mwb_regWrite;
   logic [RW-1:0] exm_rd, mwb_rd;
   logic [DW-1:0] exm_result, mwb_data;
   logic          stall, ex_valid;
   logic [DW-1:0] ex_in1, ex_in2, ex_storeData;
   logic [2:0]    ex_aluControl;
   logic [RW-1:0] ex_destReg;
   logic [4:0]    ex_ctrl;

   int chk = 0;
   int pass = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.DW(DW), .RW(RW)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .id_valid_i(id_valid),
      .id_rsData_i(id_rsData), .id_rtData_i(id_rtData), .id_imm_i(id_imm),
      .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd),
      .id_aluOp_i(id_aluOp), .id_funct_i(id_funct), .id_ctrl_i(id_ctrl),
      .exm_regWrite_i(exm_regWrite), .exm_rd_i(exm_rd), .exm_result_i(exm_result),
      .mwb_regWrite_i(mwb_regWrite), .mwb_rd_i(mwb_rd), .mwb_data_i(mwb_data),
      .stall_o(stall), .ex_valid_o(ex_valid), .ex_in1_o(ex_in1), .ex_in2_o(ex_in2),
      .ex_aluControl_o(ex_aluControl), .ex_storeData_o(ex_storeData),
      .ex_destReg_o(ex_destReg), .ex_ctrl_o(ex_ctrl)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_id(input logic v, input logic [RW-1:0] rs, rt, rd,
                           input logic [DW-1:0] rsD, rtD, imm,
                           input logic [1:0] op, input logic [5:0] fn,
                           input logic [6:0] ctrl);
      id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
      id_rsData = rsD; id_rtData = rtD; id_imm = imm;
      id_aluOp = op; id_funct = fn; id_ctrl = ctrl;
   endtask

   task automatic set_fwd(input logic ew, input logic [RW-1:0] er, input logic [DW-1:0] ed,
                          input logic mw, input logic [RW-1:0] mr, input logic [DW-1:0] md);
      exm_regWrite = ew; exm_rd = er; exm_result = ed;
      mwb_regWrite = mw; mwb_rd = mr; mwb_data = md;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0;
      drive_id(1'b1, 5'd4, 5'd4, 5'd9, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1357_9BDF,
               2'b10, 6'b101010, 7'h7F);
      set_fwd(1'b0, 5'd4, 32'h1111, 1'b0, 5'd4, 32'h2222);
      step(); step();
      chk++; if (ex_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", ex_valid); else pass++;
      chk++; if (ex_ctrl !== 5'b0) $display("FAIL rst_ctrl: got %b want 00000", ex_ctrl); else pass++;
      chk++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else pass++;
      chk++; if (ex_aluControl !== 3'b000) $display("FAIL rst_aluctl: got %b want 000", ex_aluControl); else pass++;
      chk++; if (ex_destReg !== 5'd0) $display("FAIL rst_dest: got %0d want 0", ex_destReg); else pass++;
      chk++; if ({ex_in1, ex_in2, ex_storeData} !== 96'h0)
         $display("FAIL rst_data: got %h %h %h want 0", ex_in1, ex_in2, ex_storeData); else pass++;
      drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 2'b00, 6'b0, 7'b0);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_rtype();
      drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd9, 32'h0, 2'b10, 6'b101010, C_RTYPE);
      step();
      chk++; if (ex_aluControl !== 3'b111) $display("FAIL rtype_aluctl: got %b want 111", ex_aluControl); else pass++;
      chk++; if (ex_in1 !== 32'd5) $display("FAIL rtype_in1: got %0d want 5", ex_in1); else pass++;
      chk++; if (ex_in2 !== 32'd9) $display("FAIL rtype_in2: got %0d want 9", ex_in2); else pass++;
      chk++; if (ex_destReg !== 5'd3) $display("FAIL rtype_dest: got %0d want 3", ex_destReg); else pass++;
      chk++; if ({ex_valid, ex_ctrl} !== 6'b1_10000)
         $display("FAIL rtype_ctrl: got %b/%b want 1/10000", ex_valid, ex_ctrl); else pass++;
   endtask

   task automatic test_alu_decode();
      logic [1:0] ops [9] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
      logic [5:0] fns [9] = '{6'b100010, 6'b100000, 6'b101010, 6'b100000, 6'b100010,
                              6'b100100, 6'b100101, 6'b101010, 6'b000000};
      logic [2:0] exp [9] = '{3'b010, 3'b110, 3'b010, 3'b010, 3'b110,
                              3'b000, 3'b001, 3'b111, 3'b010};
      for (int i = 0; i < 9; i++) begin
         drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, ops[i], fns[i], C_RTYPE);
         step();
         chk++; if (ex_aluControl !== exp[i])
            $display("FAIL alu_dec[%0d]: op %b fn %b got %b want %b", i, ops[i], fns[i], ex_aluControl, exp[i]);
         else pass++;
      end
   endtask

   task automatic test_forward();
      set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      drive_id(1'b1, 5'd3, 5'd3, 5'd7, 32'h11, 32'h33, 32'h0, 2'b00, 6'b0, C_RTYPE);
      step();
      set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
      #1;
      chk++; if (ex_in1 !== 32'hAA) $display("FAIL fwd_both_a: got %h want aa", ex_in1); else pass++;
      chk++; if (ex_in2 !== 32'hAA) $display("FAIL fwd_both_b: got %h want aa", ex_in2); else pass++;
      chk++; if (ex_storeData !== 32'hAA) $display("FAIL fwd_both_sd: got %h want aa", ex_storeData); else pass++;
      exm_regWrite = 1'b0;
      #1;
      chk++; if (ex_in1 !== 32'hBB) $display("FAIL fwd_mwb_a: got %h want bb", ex_in1); else pass++;
      chk++; if (ex_in2 !== 32'hBB) $display("FAIL fwd_mwb_b: got %h want bb", ex_in2); else pass++;
      mwb_regWrite = 1'b0;
      #1;
      chk++; if (ex_in1 !== 32'h11) $display("FAIL fwd_none_a: got %h want 11", ex_in1); else pass++;
      chk++; if (ex_in2 !== 32'h33) $display("FAIL fwd_none_b: got %h want 33", ex_in2); else pass++;
      // register 0 must never be forwarded even when both stages claim it
      drive_id(1'b1, 5'd0, 5'd0, 5'd7, 32'h22, 32'h44, 32'h0, 2'b00, 6'b0, C_RTYPE);
      set_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
      step();
      chk++; if (ex_in1 !== 32'h22) $display("FAIL fwd_r0_a: got %h want 22", ex_in1); else pass++;
      chk++; if (ex_in2 !== 32'h44) $display("FAIL fwd_r0_b: got %h want 44", ex_in2); else pass++;
      set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
   endtask

   task automatic test_load_use();
      drive_id(1'b1, 5'd1, 5'd4, 5'd0, 32'h100, 32'h0, 32'd8, 2'b00, 6'b0, C_LW);
      step();
      chk++; if (ex_destReg !== 5'd4) $display("FAIL lu_lw_dest: got %0d want 4", ex_destReg); else pass++;
      drive_id(1'b1, 5'd2, 5'd4, 5'd5, 32'd1, 32'd2, 32'd0, 2'b10, 6'b100000, C_RTYPE);
      #1;
      chk++; if (stall !== 1'b1) $display("FAIL lu_stall: got %b want 1", stall); else pass++;
      step();
      chk++; if ({ex_valid, ex_ctrl} !== 6'b0) $display("FAIL lu_bubble: got %b/%b want 0/00000", ex_valid, ex_ctrl); else pass++;
      chk++; if (stall !== 1'b0) $display("FAIL lu_stall_clear: got %b want 0", stall); else pass++;
      step();
      chk++; if ({ex_valid, ex_destReg, ex_aluControl} !== {1'b1, 5'd5, 3'b010})
         $display("FAIL lu_capture: got %b/%0d/%b want 1/5/010", ex_valid, ex_destReg, ex_aluControl); else pass++;
      // a load to r0 is not a hazard
      drive_id(1'b1, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'd4, 2'b00, 6'b0, C_LW);
      step();
      drive_id(1'b1, 5'd0, 5'd0, 5'd6, 32'd0, 32'd0, 32'd0, 2'b10, 6'b100000, C_RTYPE);
      #1;
      chk++; if (stall !== 1'b0) $display("FAIL lu_r0: got %b want 0", stall); else pass++;
      step();
   endtask

   task automatic test_flush();
      drive_id(1'b1, 5'd1, 5'd4, 5'd0, 32'h0, 32'h0, 32'd0, 2'b00, 6'b0, C_LW);
      step();
      drive_id(1'b1, 5'd4, 5'd2, 5'd5, 32'd1, 32'd2, 32'd0, 2'b10, 6'b100010, C_RTYPE);
      flush = 1'b1;
      #1;
      chk++; if (stall !== 1'b1) $display("FAIL fl_stall: got %b want 1", stall); else pass++;
      step();
      flush = 1'b0;
      #1;
      chk++; if ({ex_valid, ex_ctrl, stall} !== 7'b0)
         $display("FAIL fl_one_bubble: got %b/%b/%b want 0/00000/0", ex_valid, ex_ctrl, stall); else pass++;
      step();
      chk++; if ({ex_valid, ex_aluControl} !== 4'b1_110)
         $display("FAIL fl_recapture: got %b/%b want 1/110", ex_valid, ex_aluControl); else pass++;
      drive_id(1'b1, 5'd1, 5'd2, 5'd0, 32'd0, 32'd0, 32'd4, 2'b00, 6'b0, C_SW);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk++; if ({ex_valid, ex_ctrl} !== 6'b0) $display("FAIL fl_sw: got %b/%b want 0/00000", ex_valid, ex_ctrl); else pass++;
      drive_id(1'b0, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 32'd0, 2'b00, 6'b0, 7'h7F);
      step();
      chk++; if ({ex_valid, ex_ctrl} !== 6'b0) $display("FAIL invalid_ctrl: got %b/%b want 0/00000", ex_valid, ex_ctrl); else pass++;
   endtask

   task automatic test_imm();
      drive_id(1'b1, 5'd1, 5'd6, 5'd0, 32'h10, 32'h1234, 32'hFFFF_FFFC, 2'b00, 6'b0, C_SW);
      set_fwd(1'b1, 5'd6, 32'h55, 1'b0, 5'd0, 32'h0);
      step();
      chk++; if (ex_in2 !== 32'hFFFF_FFFC) $display("FAIL imm_in2: got %h want fffffffc", ex_in2); else pass++;
      chk++; if (ex_aluControl !== 3'b010) $display("FAIL imm_aluctl: got %b want 010", ex_aluControl); else pass++;
      chk++; if (ex_storeData !== 32'h55) $display("FAIL imm_sd: got %h want 55", ex_storeData); else pass++;
      chk++; if (ex_ctrl !== 5'b00100) $display("FAIL imm_ctrl: got %b want 00100", ex_ctrl); else pass++;
      set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      drive_id(1'b1, 5'd1, 5'd2, 5'd8, 32'd7, 32'd3, 32'h0000_0010, 2'b11, 6'b0, C_ADDI);
      step();
      chk++; if ({ex_in1, ex_in2, ex_destReg} !== {32'd7, 32'h10, 5'd2})
         $display("FAIL imm_addi: got %h/%h/%0d want 7/10/2", ex_in1, ex_in2, ex_destReg); else pass++;
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_alu_decode();
      test_forward();
      test_load_use();
      test_flush();
      test_imm();
      $display("%0d/%0d checks passed", pass, chk);
      $finish;
   end
endmodule
